fir_tdm_filter: RTL and testbench
=================================

Name: fir_tdm_filter

Overview:
- Parametrised multi-channel FIR filter for the I2S audio path. Successor to the fixed 16-tap highpass.
- Adds runtime-loadable coefficients, a configurable tap count and channel count, and valid/ready handshakes on both sides.
- Adds rounding and saturation back to sample width.
- Uses a single time-multiplexed MAC: one multiply per clock across all channels and taps.
- Sits between the I2S receiver frame output and the downstream I2S transmitter/DSP stage.

Parameters:
- DATA_WIDTH, 16: sample width per channel, signed two's complement.
- COEF_WIDTH, 16: coefficient width, signed Q1.(COEF_WIDTH-1).
- NUM_TAPS, 16: filter length, ≥2.
- NUM_CH, 2: channels per frame, ≥1.
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS): accumulator width, guaranteed never to overflow.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- s_valid  in  1  input frame valid.
- s_ready  out  1  input frame accepted when s_valid&&s_ready.
- s_data  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- m_valid  out  1  output frame valid.
- m_ready  in  1  downstream accepts.
- m_data  out  NUM_CH*DATA_WIDTH  filtered frame, same packing as s_data.
- m_sat  out  NUM_CH  per-channel saturation occurred in this frame; valid with m_valid.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  $clog2(NUM_TAPS)  tap index.
- coef_wr_data  in  COEF_WIDTH  coefficient value.
- coef_wr_ready  out  1  high when writes are accepted.
- flush  in  1  clear delay-line history.

Behaviour:
- Reset (resetn low at posedge):
  - state=IDLE.
  - All delay-line entries 0.
  - coef[0]=2^(COEF_WIDTH-1)-1 (0x7FFF), all other coefs 0, i.e. identity.
  - m_valid=0, m_data=0, m_sat=0.
  - s_ready and coef_wr_ready forced 0 while resetn low.
  - Reset mid-frame aborts the computation; no partial output is ever presented.
- State machine: IDLE -> MAC -> ROUND -> OUT -> IDLE.
- IDLE:
  - s_ready=1, coef_wr_ready=1.
  - On s_valid&&s_ready, each channel's sample is written into its circular delay line (per-channel write pointer advances, wraps at NUM_TAPS-1 -> 0). Accumulator cleared; go to MAC.
- MAC:
  - Exactly NUM_CH*NUM_TAPS cycles, channel-major order: c=0..NUM_CH-1, k=0..NUM_TAPS-1.
  - Each cycle: acc += coef[k]*x_c[n-k], a full-precision signed product, sign-extended to ACC_WIDTH.
  - Where k indexes older samples than exist since reset/flush, the delay line supplies 0.
  - At the end of each channel, the channel's acc is latched into a per-channel result register and acc is cleared.
- ROUND (1 cycle), per channel:
  - y = (acc + 2^(COEF_WIDTH-2)) >>> (COEF_WIDTH-1), arithmetic shift.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - m_sat[c]=1 if clipped.
  - m_data and m_sat are registered; m_valid=1 at the end of this cycle.
- Latency: with the accepting edge counted as 0, m_valid is high after edge NUM_CH*NUM_TAPS+1 (33 for the defaults).
- OUT:
  - m_valid, m_data and m_sat are held stable until m_valid&&m_ready.
  - On that edge: m_valid=0, go to IDLE, s_ready=1 in the following cycle.
  - Minimum frame period is NUM_CH*NUM_TAPS+3 cycles.
- Coefficient writes:
  - Applied only when coef_wr_ready (IDLE) and coef_wr_addr<NUM_TAPS.
  - Writes outside IDLE, or with an out-of-range address, are dropped silently.
  - A write on the same edge as a sample accept is applied, and the new value is used for that frame.
- flush:
  - Honoured only in IDLE; zeroes all delay lines and pointers.
  - If asserted on a sample-accept edge, history is cleared first, then the new sample is written as the only non-zero entry.
  - Ignored outside IDLE.
  - Coefficients are unaffected.
- s_ready is 0 in MAC/ROUND/OUT. s_valid/s_data held by the source are not consumed until the next IDLE.

Test Plan:
1. Identity after reset: reset, then frame ch0=1000, ch1=-2000. Required: m_data ch0=1000, ch1=-2000; m_sat=0; m_valid high after edge 33.
2. Impulse response:
   - Setup: write coef[k]=0x0100*(k+1), k=0..15.
   - Stimulus: ch0 sequence 0x7FFF followed by 15 zeros; ch1 all zero.
   - Required: ch0 outputs 256*(k+1) for k=0..15; ch1 always 0; 17th output (ch0) 0.
3. Saturation:
   - Setup: coef[0]=coef[1]=0x7FFF, others 0.
   - Stimulus: ch0=30000 twice.
   - Required: first output 29999 with m_sat=00; second output 32767 with m_sat[0]=1. Repeat with -30000: second output -32768.
4. Backpressure: hold m_ready=0 for 10 cycles after m_valid, with s_valid=1 and a new frame on s_data. Required: m_data/m_valid/m_sat stable; s_ready=0; new frame consumed only after the m_ready handshake.
5. Coef write and flush gating: pulse coef_wr_en during MAC. Required: coef_wr_ready=0, coefficient unchanged (next identity frame passes through). Then flush in IDLE followed by frame 500. Required: output 500 with no contribution from history.
6. Reset mid-MAC at cycle 10 of MAC: m_valid stays 0, no output emitted. The next frame of 123 yields 123, confirming coefs and history are reset.

Source files
------------

// File: rtl/fir_tdm_filter.sv
// ---------------------------------------------------------------------------
// fir_tdm_filter
//
// Multi-channel FIR filter built around one time-multiplexed multiplier.
// A frame carries one sample per channel; every channel has its own circular
// delay line, and all channels share one runtime-loadable coefficient set.
// Each frame is processed as NUM_CH*NUM_TAPS MAC cycles (channel-major),
// then one round/saturate cycle, and the result is held until the
// downstream accepts it.
//
// Ports:
//   clk           clock
//   resetn        synchronous active-low reset
//   s_valid       input frame valid
//   s_ready       input frame accepted on s_valid && s_ready (IDLE only)
//   s_data        NUM_CH packed samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   m_valid       output frame valid
//   m_ready       downstream accepts output frame
//   m_data        filtered frame, same packing as s_data
//   m_sat         per-channel "result was clipped" flags, valid with m_valid
//   coef_wr_en    coefficient write strobe
//   coef_wr_addr  tap index of the coefficient write
//   coef_wr_data  coefficient value, signed Q1.(COEF_WIDTH-1)
//   coef_wr_ready high when coefficient writes are accepted (IDLE only)
//   flush         clear delay-line history (IDLE only)
// ---------------------------------------------------------------------------
module fir_tdm_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 16,
    parameter int NUM_CH     = 2,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   m_data,
    output logic [NUM_CH-1:0]              m_sat,
    input  logic                           coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]    coef_wr_addr,
    input  logic [COEF_WIDTH-1:0]          coef_wr_data,
    output logic                           coef_wr_ready,
    input  logic                           flush
);

    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    // Half an LSB of the output in Q(COEF_WIDTH-1) units: round half up.
    localparam logic signed [ACC_WIDTH-1:0] RND_BIAS = ACC_WIDTH'(1) << (COEF_WIDTH - 2);
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX    = (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN    = ~Y_MAX;
    // Largest positive coefficient (just under 1.0) makes the filter an identity.
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = {1'b0, {(COEF_WIDTH-1){1'b1}}};

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]                     r_state;
    logic [ADDR_W-1:0]              r_wp;       // next write slot, shared by all channels
    logic [ADDR_W-1:0]              r_newest;   // slot holding the sample of this frame
    logic [ADDR_W-1:0]              r_rd;       // delay-line slot read this MAC cycle
    logic [CH_W-1:0]                r_ch;
    logic [ADDR_W-1:0]              r_tap;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    r_res [NUM_CH];
    logic signed [COEF_WIDTH-1:0]   r_coef [NUM_TAPS];
    logic                           r_m_valid;
    logic [NUM_CH*DATA_WIDTH-1:0]   r_m_data;
    logic [NUM_CH-1:0]              r_m_sat;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    logic                           w_idle;
    logic                           w_accept;
    logic                           w_flush_en;
    logic                           w_coef_we;
    logic [ADDR_W-1:0]              w_wr_pos;
    logic [ADDR_W-1:0]              w_wr_pos_next;
    logic signed [DATA_WIDTH-1:0]   w_tap_x [NUM_CH];
    logic signed [DATA_WIDTH-1:0]   w_x;
    logic signed [COEF_WIDTH-1:0]   w_c;
    logic signed [PROD_W-1:0]       w_prod;
    logic signed [ACC_WIDTH-1:0]    w_acc_sum;
    logic signed [ACC_WIDTH-1:0]    w_rnd [NUM_CH];
    logic signed [ACC_WIDTH-1:0]    w_shr [NUM_CH];
    logic                           w_hi  [NUM_CH];
    logic                           w_lo  [NUM_CH];
    logic [DATA_WIDTH-1:0]          w_y   [NUM_CH];

    assign w_idle        = (r_state == S_IDLE);
    assign s_ready       = resetn && w_idle;
    assign coef_wr_ready = resetn && w_idle;
    assign w_accept      = s_valid && s_ready;
    assign w_flush_en    = w_idle && flush;
    assign w_coef_we     = coef_wr_en && coef_wr_ready && (32'(coef_wr_addr) < NUM_TAPS);

    // A flush on the accept edge restarts history, so the new sample lands in slot 0.
    assign w_wr_pos      = w_flush_en ? '0 : r_wp;
    assign w_wr_pos_next = (w_wr_pos == LAST_TAP) ? '0 : w_wr_pos + ADDR_W'(1);

    // MAC datapath: one full-precision signed product per cycle.
    assign w_x       = w_tap_x[r_ch];
    assign w_c       = r_coef[r_tap];
    assign w_prod    = PROD_W'(w_c) * PROD_W'(w_x);
    assign w_acc_sum = r_acc + ACC_WIDTH'(w_prod);

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_sat   = r_m_sat;

    // -----------------------------------------------------------------------
    // Per-channel delay lines and round/saturate
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic signed [DATA_WIDTH-1:0] r_dl [NUM_TAPS];

            // Zeroed history stands in for samples older than reset/flush.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < NUM_TAPS; i++) r_dl[i] <= '0;
                end else begin
                    if (w_flush_en) begin
                        for (int i = 0; i < NUM_TAPS; i++) r_dl[i] <= '0;
                    end
                    if (w_accept) begin
                        r_dl[w_wr_pos] <= s_data[gi*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign w_tap_x[gi] = r_dl[r_rd];

            assign w_rnd[gi] = r_res[gi] + RND_BIAS;
            assign w_shr[gi] = w_rnd[gi] >>> (COEF_WIDTH - 1);
            assign w_hi[gi]  = (w_shr[gi] > Y_MAX);
            assign w_lo[gi]  = (w_shr[gi] < Y_MIN);
            assign w_y[gi]   = w_hi[gi] ? Y_MAX[DATA_WIDTH-1:0] :
                               w_lo[gi] ? Y_MIN[DATA_WIDTH-1:0] :
                                          w_shr[gi][DATA_WIDTH-1:0];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control, accumulator, coefficients and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_wp      <= '0;
            r_newest  <= '0;
            r_rd      <= '0;
            r_ch      <= '0;
            r_tap     <= '0;
            r_acc     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= '0;
            for (int c = 0; c < NUM_CH; c++) r_res[c] <= '0;
            for (int k = 0; k < NUM_TAPS; k++) r_coef[k] <= '0;
            r_coef[0] <= COEF_ONE;
        end else begin
            if (w_coef_we) begin
                r_coef[coef_wr_addr] <= coef_wr_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_flush_en) begin
                        r_wp <= '0;
                    end
                    if (w_accept) begin
                        r_wp     <= w_wr_pos_next;
                        r_newest <= w_wr_pos;
                        r_rd     <= w_wr_pos;
                        r_ch     <= '0;
                        r_tap    <= '0;
                        r_acc    <= '0;
                        r_state  <= S_MAC;
                    end
                end

                S_MAC: begin
                    if (r_tap == LAST_TAP) begin
                        // Channel done: park its sum, restart from the newest sample.
                        r_res[r_ch] <= w_acc_sum;
                        r_acc       <= '0;
                        r_tap       <= '0;
                        r_rd        <= r_newest;
                        if (r_ch == LAST_CH) begin
                            r_state <= S_ROUND;
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end else begin
                        r_acc <= w_acc_sum;
                        r_tap <= r_tap + ADDR_W'(1);
                        // Walk backwards in time through the circular buffer.
                        r_rd  <= (r_rd == '0) ? LAST_TAP : r_rd - ADDR_W'(1);
                    end
                end

                S_ROUND: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_m_data[c*DATA_WIDTH +: DATA_WIDTH] <= w_y[c];
                        r_m_sat[c] <= w_hi[c] | w_lo[c];
                    end
                    r_m_valid <= 1'b1;
                    r_state   <= S_OUT;
                end

                S_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_filter.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_filter
//
// Directed bench for fir_tdm_filter with default parameters (16-bit data,
// 16-bit coefficients, 16 taps, 2 channels). Expected values are computed
// by hand from y = (acc + 2^14) >>> 15 with saturation to 16 bits.
// ---------------------------------------------------------------------------
module tb_fir_tdm_filter;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int NT  = 16;
    localparam int NCH = 2;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  s_valid;
    logic                  s_ready;
    logic [NCH*DW-1:0]     s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [NCH*DW-1:0]     m_data;
    logic [NCH-1:0]        m_sat;
    logic                  coef_wr_en;
    logic [$clog2(NT)-1:0] coef_wr_addr;
    logic [CW-1:0]         coef_wr_data;
    logic                  coef_wr_ready;
    logic                  flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_tdm_filter #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .NUM_TAPS   (NT),
        .NUM_CH     (NCH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_sat         (m_sat),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .coef_wr_ready (coef_wr_ready),
        .flush         (flush)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] och(input int c);
        return $signed(m_data[c*DW +: DW]);
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int addr, input logic [CW-1:0] data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr[$clog2(NT)-1:0];
        coef_wr_data = data;
        step();
        coef_wr_en   = 1'b0;
    endtask

    // Present one frame and return just after the accepting edge.
    task automatic send(input logic signed [DW-1:0] x0, input logic signed [DW-1:0] x1, input logic fl);
        int n;
        s_data  = {x1, x0};
        s_valid = 1'b1;
        flush   = fl;
        n = 0;
        while (!s_ready && n < 200) begin
            step();
            n++;
        end
        chk("send_ready", s_ready, 1);
        step();
        s_valid = 1'b0;
        flush   = 1'b0;
        $display("frame in  ch0=%0d ch1=%0d flush=%0b", x0, x1, fl);
    endtask

    // Wait (bounded) for an output frame, check it, then complete the handshake.
    task automatic recv(input string tag, input int exp_lat,
                        input logic signed [63:0] e0, input logic signed [63:0] e1,
                        input logic [NCH-1:0] esat);
        int n;
        n = 0;
        while (!m_valid && n < 100) begin
            step();
            n++;
        end
        $display("frame out %s ch0=%0d ch1=%0d sat=%b after %0d cycles", tag, och(0), och(1), m_sat, n);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_ch0"}, och(0), e0);
        chk({tag, "_ch1"}, och(1), e1);
        chk({tag, "_sat"}, m_sat, esat);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk({tag, "_valid_drop"}, m_valid, 0);
    endtask

    initial begin
        int seen;
        resetn       = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        m_ready      = 1'b0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        flush        = 1'b0;

        // ---- reset state ----
        step(); step(); step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_sat", m_sat, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_coef_wr_ready", coef_wr_ready, 0);
        resetn = 1'b1;
        #1;
        chk("idle_s_ready", s_ready, 1);
        chk("idle_coef_wr_ready", coef_wr_ready, 1);

        // ---- 1: identity after reset ----
        send(16'sd1000, -16'sd2000, 1'b0);
        recv("t1", 33, 1000, -2000, 2'b00);

        // ---- 2: impulse response ----
        for (int k = 0; k < NT; k++) wcoef(k, 16'(16'h0100 * (k + 1)));
        for (int n = 0; n <= NT; n++) begin
            send((n == 0) ? 16'sd32767 : 16'sd0, 16'sd0, (n == 0));
            recv($sformatf("t2_%0d", n), 33, (n < NT) ? 256 * (n + 1) : 0, 0, 2'b00);
        end

        // ---- 3: saturation ----
        for (int k = 0; k < NT; k++) wcoef(k, (k < 2) ? 16'h7FFF : 16'h0000);
        send(16'sd30000, 16'sd0, 1'b1);
        recv("t3_pos1", 33, 29999, 0, 2'b00);
        send(16'sd30000, 16'sd0, 1'b0);
        recv("t3_pos2", 33, 32767, 0, 2'b01);
        send(-16'sd30000, 16'sd0, 1'b1);
        recv("t3_neg1", 33, -29999, 0, 2'b00);
        send(-16'sd30000, 16'sd0, 1'b0);
        recv("t3_neg2", 33, -32768, 0, 2'b01);

        // ---- 4: backpressure ----
        wcoef(1, 16'h0000);
        send(16'sd111, -16'sd222, 1'b0);
        seen = 0;
        while (!m_valid && seen < 100) begin
            step();
            seen++;
        end
        chk("t4_latency", seen, 33);
        s_data  = {-16'sd333, 16'sd777};
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t4_hold_valid_%0d", i), m_valid, 1);
            chk($sformatf("t4_hold_ch0_%0d", i), och(0), 111);
            chk($sformatf("t4_hold_ch1_%0d", i), och(1), -222);
            chk($sformatf("t4_hold_sat_%0d", i), m_sat, 0);
            chk($sformatf("t4_hold_s_ready_%0d", i), s_ready, 0);
        end
        $display("frame out t4a ch0=%0d ch1=%0d sat=%b held 10 cycles", och(0), och(1), m_sat);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t4_valid_drop", m_valid, 0);
        chk("t4_s_ready_after", s_ready, 1);
        step();
        s_valid = 1'b0;
        $display("frame in  ch0=777 ch1=-333 flush=0");
        recv("t4b", 33, 777, -333, 2'b00);

        // ---- 5: coefficient write and flush gating ----
        send(16'sd321, -16'sd321, 1'b0);
        step(); step(); step();
        chk("t5_coef_wr_ready_mac", coef_wr_ready, 0);
        chk("t5_s_ready_mac", s_ready, 0);
        coef_wr_en   = 1'b1;
        coef_wr_addr = '0;
        coef_wr_data = 16'h1234;
        step();
        coef_wr_en   = 1'b0;
        recv("t5a", 29, 321, -321, 2'b00);
        send(16'sd45, -16'sd45, 1'b0);
        recv("t5b", 33, 45, -45, 2'b00);
        // Half-weight second tap exposes any surviving history.
        wcoef(1, 16'h4000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send(16'sd500, -16'sd500, 1'b0);
        recv("t5_flushed", 33, 500, -500, 2'b00);
        // Flush during MAC is ignored: history from the 500 frame still counts.
        send(16'sd200, -16'sd200, 1'b0);
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        recv("t5_flush_ignored", 30, 450, -450, 2'b00);

        // ---- 6: reset in the middle of MAC ----
        send(16'sd999, -16'sd999, 1'b0);
        for (int i = 0; i < 10; i++) step();
        resetn = 1'b0;
        #1;
        chk("t6_s_ready_in_reset", s_ready, 0);
        step();
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_valid) seen++;
        end
        chk("t6_no_output", seen, 0);
        chk("t6_s_ready", s_ready, 1);
        send(16'sd123, -16'sd123, 1'b0);
        recv("t6", 33, 123, -123, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
